// File: rtl/part_n_trgt_ctrl.sv
// part_n_trgt_ctrl
// Freezes mission-clock channels of a system under test on each rising
// mission-clock edge, downloads the channel input vector over a get
// transport, uploads the channel output vector over a put transport, then
// releases the channel. Edges are sampled as data on the utility clock.
//
// Ports
//   clk_i, rst_i        utility clock, asynchronous active-high reset
//   clk_h_i             NCH mission clocks (sampled as data)
//   freeze_clk_o        per-channel mission-clock block request
//   get_req_o/get_ch_o  download request and channel
//   get_vld_i/get_data_i download response strobe and payload
//   put_vld_o/put_ch_o/put_data_o  upload request, payload held until accepted
//   put_rdy_i           upload accept
//   tx_data_i           per-channel SUT outputs, channel c at [c*DW +: DW]
//   rx_data_o           per-channel downloaded vectors, held until overwritten
//   rx_upd_o            one-cycle pulse per channel on rx_data_o update
//   ovr_o               sticky per-channel edge-overrun flags
//   wdog_err_o          sticky watchdog error
//   state_o             FSM state (0 IDLE, 1 GET, 2 PUT, 3 ERR)
//
// Handshakes: get completes in the cycle get_req_o=1 and get_vld_i=1;
// put completes in the cycle put_vld_o=1 and put_rdy_i=1. put_vld_o,
// put_ch_o and put_data_o stay stable until that cycle. Strobes seen
// outside their own state are ignored.
module part_n_trgt_ctrl #(
   parameter int NCH      = 4,
   parameter int DW       = 9,
   parameter int WDOG_MAX = 10000,
   parameter bit GET_EN   = 1'b1,
   parameter bit PUT_EN   = 1'b1,
   localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int WW      = $clog2(WDOG_MAX + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NCH-1:0]      clk_h_i,
   output logic [NCH-1:0]      freeze_clk_o,
   output logic                get_req_o,
   output logic [CW-1:0]       get_ch_o,
   input  logic                get_vld_i,
   input  logic [DW-1:0]       get_data_i,
   output logic                put_vld_o,
   output logic [CW-1:0]       put_ch_o,
   output logic [DW-1:0]       put_data_o,
   input  logic                put_rdy_i,
   input  logic [NCH*DW-1:0]   tx_data_i,
   output logic [NCH*DW-1:0]   rx_data_o,
   output logic [NCH-1:0]      rx_upd_o,
   output logic [NCH-1:0]      ovr_o,
   output logic                wdog_err_o,
   output logic [1:0]          state_o
);

   generate
      if (!GET_EN && !PUT_EN) begin : g_bad_en
         $error("part_n_trgt_ctrl: GET_EN and PUT_EN cannot both be 0");
      end
      if (NCH < 1 || NCH > 8) begin : g_bad_nch
         $error("part_n_trgt_ctrl: NCH must be 1..8");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_GET = 2'd1, S_PUT = 2'd2, S_ERR = 2'd3} state_t;

   state_t          state;
   logic [NCH-1:0]  clk_h_q;
   logic            armed;      // low for the first cycle after reset so a high clock is not an edge
   logic [NCH-1:0]  pend;
   logic [CW-1:0]   rr_ptr;
   logic [CW-1:0]   ch;
   logic [WW-1:0]   wdog;

   logic [NCH-1:0]  edge_det, svc, drop, accept;
   logic [NCH-1:0]  take_mask, ack_mask;
   logic [NCH-1:0]  pend_d, freeze_d, ovr_d;
   logic            sel_found, take, get_ack, put_ack, wdog_hit, go_err;
   logic [CW-1:0]   sel_ch;

   assign state_o = state;

   // Round-robin pick, scanning from the channel after the last one served.
   always_comb begin
      int idx;
      idx       = 0;
      sel_found = 1'b0;
      sel_ch    = '0;
      for (int i = 1; i <= NCH; i++) begin
         idx = (int'(rr_ptr) + i) % NCH;
         if (!sel_found && pend[idx]) begin
            sel_found = 1'b1;
            sel_ch    = CW'(idx);
         end
      end
   end

   always_comb begin
      svc       = '0;
      take_mask = '0;
      ack_mask  = '0;
      if (state == S_GET || state == S_PUT) svc[ch] = 1'b1;

      edge_det = clk_h_i & ~clk_h_q & {NCH{armed}};
      // A channel already pending or in service cannot take another edge.
      drop     = edge_det & (pend | svc);
      accept   = edge_det & ~drop;

      take     = (state == S_IDLE) && sel_found;
      get_ack  = (state == S_GET) && get_vld_i;
      put_ack  = (state == S_PUT) && put_rdy_i;
      wdog_hit = (wdog == WW'(WDOG_MAX - 1));
      go_err   = ((state == S_GET && !get_vld_i) || (state == S_PUT && !put_rdy_i)) && wdog_hit;

      if (take)    take_mask[sel_ch] = 1'b1;
      if (get_ack) ack_mask[ch]      = 1'b1;

      if (state == S_ERR) begin
         pend_d = pend;
         ovr_d  = ovr_o;
      end else begin
         pend_d = (pend & ~take_mask) | accept;
         ovr_d  = ovr_o | drop;
      end

      if (state == S_ERR || go_err) begin
         freeze_d = '1;
      end else begin
         freeze_d = (freeze_clk_o & ~ack_mask) | (GET_EN ? accept : '0);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         clk_h_q      <= '0;
         armed        <= 1'b0;
         pend         <= '0;
         rr_ptr       <= CW'(NCH - 1);
         ch           <= '0;
         wdog         <= '0;
         freeze_clk_o <= '0;
         get_req_o    <= 1'b0;
         get_ch_o     <= '0;
         put_vld_o    <= 1'b0;
         put_ch_o     <= '0;
         put_data_o   <= '0;
         rx_data_o    <= '0;
         rx_upd_o     <= '0;
         ovr_o        <= '0;
         wdog_err_o   <= 1'b0;
      end else begin
         clk_h_q      <= clk_h_i;
         armed        <= 1'b1;
         pend         <= pend_d;
         ovr_o        <= ovr_d;
         freeze_clk_o <= freeze_d;
         rx_upd_o     <= '0;

         case (state)
            S_IDLE: begin
               if (take) begin
                  rr_ptr <= sel_ch;
                  ch     <= sel_ch;
                  wdog   <= '0;
                  if (GET_EN) begin
                     state     <= S_GET;
                     get_req_o <= 1'b1;
                     get_ch_o  <= sel_ch;
                  end else begin
                     state      <= S_PUT;
                     put_vld_o  <= 1'b1;
                     put_ch_o   <= sel_ch;
                     put_data_o <= tx_data_i[sel_ch*DW +: DW];
                  end
               end
            end
            S_GET: begin
               if (get_ack) begin
                  rx_data_o[ch*DW +: DW] <= get_data_i;
                  rx_upd_o[ch]           <= 1'b1;
                  get_req_o              <= 1'b0;
                  if (PUT_EN) begin
                     state      <= S_PUT;
                     wdog       <= '0;
                     put_vld_o  <= 1'b1;
                     put_ch_o   <= ch;
                     put_data_o <= tx_data_i[ch*DW +: DW];
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (go_err) begin
                  state      <= S_ERR;
                  get_req_o  <= 1'b0;
                  wdog_err_o <= 1'b1;
               end else begin
                  wdog <= wdog + WW'(1);
               end
            end
            S_PUT: begin
               if (put_ack) begin
                  state     <= S_IDLE;
                  put_vld_o <= 1'b0;
               end else if (go_err) begin
                  state      <= S_ERR;
                  put_vld_o  <= 1'b0;
                  wdog_err_o <= 1'b1;
               end else begin
                  wdog <= wdog + WW'(1);
               end
            end
            default: begin
               // ERR is terminal until reset.
               get_req_o  <= 1'b0;
               put_vld_o  <= 1'b0;
               wdog_err_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_part_n_trgt_ctrl.sv
module tb_part_n_trgt_ctrl;

   localparam int NCH = 4;
   localparam int DW  = 9;
   localparam logic [NCH*DW-1:0] TX0 = {9'h1C3, 9'h0B2, 9'h1A1, 9'h090};

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NCH-1:0]    clk_h = '0;
   logic [NCH-1:0]    freeze_clk_o;
   logic              get_req_o;
   logic [1:0]        get_ch_o;
   logic              get_vld = 1'b0;
   logic [DW-1:0]     get_data = '0;
   logic              put_vld_o;
   logic [1:0]        put_ch_o;
   logic [DW-1:0]     put_data_o;
   logic              put_rdy = 1'b0;
   logic [NCH*DW-1:0] tx_data = TX0;
   logic [NCH*DW-1:0] rx_data_o;
   logic [NCH-1:0]    rx_upd_o;
   logic [NCH-1:0]    ovr_o;
   logic              wdog_err_o;
   logic [1:0]        state_o;

   int checks = 0;
   int errors = 0;
   int upd1_cnt = 0;

   part_n_trgt_ctrl #(.NCH(NCH), .DW(DW), .WDOG_MAX(16), .GET_EN(1'b1), .PUT_EN(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .clk_h_i(clk_h), .freeze_clk_o(freeze_clk_o),
      .get_req_o(get_req_o), .get_ch_o(get_ch_o), .get_vld_i(get_vld), .get_data_i(get_data),
      .put_vld_o(put_vld_o), .put_ch_o(put_ch_o), .put_data_o(put_data_o), .put_rdy_i(put_rdy),
      .tx_data_i(tx_data), .rx_data_o(rx_data_o), .rx_upd_o(rx_upd_o), .ovr_o(ovr_o),
      .wdog_err_o(wdog_err_o), .state_o(state_o)
   );

   always @(negedge clk) if (rx_upd_o[1] === 1'b1) upd1_cnt++;

   function automatic logic [DW-1:0] rx_ch(input int c);
      return rx_data_o[c*DW +: DW];
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      clk_h = '0; get_vld = 1'b0; put_rdy = 1'b0; tx_data = TX0;
      tick(); tick();
   endtask

   task automatic do_reset();
      clk_h = '0; rst = 1'b1;
      tick();
      rst = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset();
      clk_h = 4'b0010;
      rst = 1'b1;
      tick(); tick();
      checks++; if ({freeze_clk_o, get_req_o, put_vld_o, rx_upd_o, ovr_o, wdog_err_o} !== '0) begin
         errors++; $display("FAIL reset_outputs: got frz=%b greq=%b pvld=%b upd=%b ovr=%b werr=%b want all 0",
                            freeze_clk_o, get_req_o, put_vld_o, rx_upd_o, ovr_o, wdog_err_o); end
      checks++; if (state_o !== 2'd0 || rx_data_o !== '0) begin
         errors++; $display("FAIL reset_state: got state=%0d rx=%h want 0/0", state_o, rx_data_o); end
      rst = 1'b0;
      tick(); tick(); tick();
      checks++; if (freeze_clk_o !== 4'b0000 || state_o !== 2'd0) begin
         errors++; $display("FAIL reset_high_clk_no_edge: got frz=%b state=%0d want 0000/0", freeze_clk_o, state_o); end
      get_vld = 1'b1; get_data = 9'h0AA;
      tick(); tick();
      checks++; if (rx_upd_o !== 4'b0000 || rx_data_o !== '0) begin
         errors++; $display("FAIL reset_vld_ignored: got upd=%b rx=%h want 0/0", rx_upd_o, rx_data_o); end
      get_vld = 1'b0;
   endtask

   task automatic test_basic();
      quiet();
      clk_h[2] = 1'b1;
      tick();
      checks++; if (freeze_clk_o !== 4'b0100 || get_req_o !== 1'b0) begin
         errors++; $display("FAIL basic_pend: got frz=%b greq=%b want 0100/0", freeze_clk_o, get_req_o); end
      tick();
      checks++; if (state_o !== 2'd1 || get_req_o !== 1'b1 || get_ch_o !== 2'd2 || freeze_clk_o !== 4'b0100) begin
         errors++; $display("FAIL basic_get: got st=%0d greq=%b gch=%0d frz=%b want 1/1/2/0100",
                            state_o, get_req_o, get_ch_o, freeze_clk_o); end
      get_vld = 1'b1; get_data = 9'h1A5;
      tick();
      checks++; if (rx_upd_o !== 4'b0100 || rx_ch(2) !== 9'h1A5 || freeze_clk_o !== 4'b0000) begin
         errors++; $display("FAIL basic_rx: got upd=%b rx2=%h frz=%b want 0100/1a5/0000", rx_upd_o, rx_ch(2), freeze_clk_o); end
      checks++; if (state_o !== 2'd2 || put_vld_o !== 1'b1 || put_ch_o !== 2'd2 || put_data_o !== 9'h0B2 || get_req_o !== 1'b0) begin
         errors++; $display("FAIL basic_put: got st=%0d pv=%b pch=%0d pd=%h greq=%b want 2/1/2/0b2/0",
                            state_o, put_vld_o, put_ch_o, put_data_o, get_req_o); end
      get_vld = 1'b0; put_rdy = 1'b1;
      tick();
      checks++; if (state_o !== 2'd0 || put_vld_o !== 1'b0 || rx_upd_o !== 4'b0000) begin
         errors++; $display("FAIL basic_done: got st=%0d pv=%b upd=%b want 0/0/0000", state_o, put_vld_o, rx_upd_o); end
      put_rdy = 1'b0;
   endtask

   task automatic test_order();
      do_reset();
      clk_h = 4'b1001;
      tick();
      checks++; if (freeze_clk_o !== 4'b1001) begin
         errors++; $display("FAIL order_freeze: got %b want 1001", freeze_clk_o); end
      tick();
      checks++; if (get_req_o !== 1'b1 || get_ch_o !== 2'd0) begin
         errors++; $display("FAIL order_get_first: got greq=%b gch=%0d want 1/0", get_req_o, get_ch_o); end
      get_vld = 1'b1; get_data = 9'h055; put_rdy = 1'b1;
      tick();
      checks++; if (put_ch_o !== 2'd0 || put_data_o !== 9'h090 || rx_upd_o !== 4'b0001 || freeze_clk_o !== 4'b1000) begin
         errors++; $display("FAIL order_put_first: got pch=%0d pd=%h upd=%b frz=%b want 0/090/0001/1000",
                            put_ch_o, put_data_o, rx_upd_o, freeze_clk_o); end
      get_vld = 1'b0;
      tick(); tick();
      checks++; if (get_req_o !== 1'b1 || get_ch_o !== 2'd3) begin
         errors++; $display("FAIL order_get_second: got greq=%b gch=%0d want 1/3", get_req_o, get_ch_o); end
      get_vld = 1'b1; get_data = 9'h133;
      tick();
      checks++; if (put_ch_o !== 2'd3 || put_data_o !== 9'h1C3 || rx_ch(3) !== 9'h133 || freeze_clk_o !== 4'b0000) begin
         errors++; $display("FAIL order_put_second: got pch=%0d pd=%h rx3=%h frz=%b want 3/1c3/133/0000",
                            put_ch_o, put_data_o, rx_ch(3), freeze_clk_o); end
      get_vld = 1'b0;
      tick();
      put_rdy = 1'b0;
   endtask

   task automatic test_put_hold();
      logic [DW-1:0] v;
      quiet();
      clk_h[1] = 1'b1;
      tick(); tick();
      get_vld = 1'b1; get_data = 9'h0F0;
      tick();
      get_vld = 1'b0;
      for (int i = 0; i < 5; i++) begin
         v = 9'h0C0 + 9'(i);
         tx_data[1*DW +: DW] = v;
         tick();
         checks++; if (put_vld_o !== 1'b1 || put_data_o !== 9'h1A1 || state_o !== 2'd2) begin
            errors++; $display("FAIL put_hold_%0d: got pv=%b pd=%h st=%0d want 1/1a1/2", i, put_vld_o, put_data_o, state_o); end
      end
      put_rdy = 1'b1;
      tick();
      checks++; if (state_o !== 2'd0 || put_vld_o !== 1'b0) begin
         errors++; $display("FAIL put_hold_release: got st=%0d pv=%b want 0/0", state_o, put_vld_o); end
      put_rdy = 1'b0; tx_data = TX0;
   endtask

   task automatic test_overrun();
      int start_cnt;
      quiet();
      start_cnt = upd1_cnt;
      checks++; if (ovr_o !== 4'b0000) begin
         errors++; $display("FAIL ovr_initial: got %b want 0000", ovr_o); end
      clk_h[0] = 1'b1;
      tick(); tick();
      clk_h[1] = 1'b1;
      tick();
      clk_h[1] = 1'b0;
      tick();
      clk_h[1] = 1'b1;
      tick();
      checks++; if (ovr_o !== 4'b0010 || state_o !== 2'd1 || freeze_clk_o !== 4'b0011) begin
         errors++; $display("FAIL ovr_set: got ovr=%b st=%0d frz=%b want 0010/1/0011", ovr_o, state_o, freeze_clk_o); end
      get_vld = 1'b1; get_data = 9'h011; put_rdy = 1'b1;
      tick();
      get_vld = 1'b0;
      tick(); tick();
      checks++; if (get_req_o !== 1'b1 || get_ch_o !== 2'd1) begin
         errors++; $display("FAIL ovr_serve_ch1: got greq=%b gch=%0d want 1/1", get_req_o, get_ch_o); end
      get_vld = 1'b1; get_data = 9'h0E1;
      tick();
      get_vld = 1'b0;
      repeat (6) tick();
      checks++; if (upd1_cnt - start_cnt !== 1 || ovr_o !== 4'b0010 || state_o !== 2'd0) begin
         errors++; $display("FAIL ovr_single_service: got services=%0d ovr=%b st=%0d want 1/0010/0",
                            upd1_cnt - start_cnt, ovr_o, state_o); end
      put_rdy = 1'b0;
   endtask

   task automatic test_reset_in_put();
      logic seen;
      quiet();
      clk_h[2] = 1'b1;
      tick(); tick();
      get_vld = 1'b1; get_data = 9'h077;
      tick();
      get_vld = 1'b0;
      tick(); tick();
      checks++; if (put_vld_o !== 1'b1 || put_ch_o !== 2'd2) begin
         errors++; $display("FAIL rip_in_put: got pv=%b pch=%0d want 1/2", put_vld_o, put_ch_o); end
      #2 rst = 1'b1;
      #1;
      checks++; if (put_vld_o !== 1'b0 || state_o !== 2'd0 || rx_data_o !== '0 || ovr_o !== 4'b0000) begin
         errors++; $display("FAIL rip_async_clear: got pv=%b st=%0d rx=%h ovr=%b want 0/0/0/0",
                            put_vld_o, state_o, rx_data_o, ovr_o); end
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen = seen | put_vld_o | get_req_o;
      end
      checks++; if (seen !== 1'b0 || freeze_clk_o !== 4'b0000) begin
         errors++; $display("FAIL rip_no_later_put: got activity=%b frz=%b want 0/0000", seen, freeze_clk_o); end
   endtask

   task automatic test_wdog();
      quiet();
      clk_h[3] = 1'b1;
      tick(); tick();
      repeat (15) tick();
      checks++; if (state_o !== 2'd1 || wdog_err_o !== 1'b0) begin
         errors++; $display("FAIL wdog_before: got st=%0d werr=%b want 1/0", state_o, wdog_err_o); end
      tick();
      checks++; if (state_o !== 2'd3 || wdog_err_o !== 1'b1 || freeze_clk_o !== 4'hF || get_req_o !== 1'b0 || put_vld_o !== 1'b0) begin
         errors++; $display("FAIL wdog_err: got st=%0d werr=%b frz=%h greq=%b pv=%b want 3/1/f/0/0",
                            state_o, wdog_err_o, freeze_clk_o, get_req_o, put_vld_o); end
      get_vld = 1'b1; put_rdy = 1'b1;
      tick(); tick(); tick();
      checks++; if (state_o !== 2'd3 || wdog_err_o !== 1'b1 || freeze_clk_o !== 4'hF || rx_upd_o !== 4'b0000) begin
         errors++; $display("FAIL wdog_sticky: got st=%0d werr=%b frz=%h upd=%b want 3/1/f/0000",
                            state_o, wdog_err_o, freeze_clk_o, rx_upd_o); end
      get_vld = 1'b0; put_rdy = 1'b0;
      rst = 1'b1;
      tick();
      checks++; if (wdog_err_o !== 1'b0 || freeze_clk_o !== 4'h0 || state_o !== 2'd0) begin
         errors++; $display("FAIL wdog_reset: got werr=%b frz=%h st=%0d want 0/0/0", wdog_err_o, freeze_clk_o, state_o); end
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_order();
      test_put_hold();
      test_overrun();
      test_reset_in_put();
      test_wdog();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Time limit so a stuck run still ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/part_n_trgt_ctrl.md
PART_N_TRGT_CTRL -- requirements
Module: part_n_trgt_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of mission-clock channels, 1..8.
REQ-002 Parameter DW, default 9: payload width per channel, {valid, data}.
REQ-003 Parameter WDOG_MAX, default 10000: cycles allowed per transport handshake.
REQ-004 Parameter GET_EN, default 1: enables download (get) per serviced edge.
REQ-005 Parameter PUT_EN, default 1: enables upload (put) per serviced edge; GET_EN=PUT_EN=0 SHALL be an elaboration error.
REQ-006 clk_i  in  1  utility clock; all logic on its rising edge; one clock only.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 clk_h_i  in  NCH  mission clocks, sampled as data on clk_i.
REQ-009 freeze_clk_o  out  NCH  per-channel mission-clock block request.
REQ-010 get_req_o / get_ch_o  out  1 / clog2(NCH)  download request and channel.
REQ-011 get_vld_i / get_data_i  in  1 / DW  download response strobe and payload.
REQ-012 put_vld_o / put_ch_o / put_data_o  out  1 / clog2(NCH) / DW  upload request.
REQ-013 put_rdy_i  in  1  upload accept.
REQ-014 tx_data_i  in  NCH*DW  per-channel SUT output vectors, channel c at [c*DW +: DW].
REQ-015 rx_data_o  out  NCH*DW  per-channel downloaded vectors, held until overwritten.
REQ-016 rx_upd_o  out  NCH  one-cycle pulse when rx_data_o channel c updates.
REQ-017 ovr_o  out  NCH  sticky per-channel edge-overrun flag.
REQ-018 wdog_err_o  out  1  sticky watchdog error.

Function
REQ-019 Edge detect: clk_h_q[c] is the registered clk_h_i[c]; edge[c] = clk_h_i[c] & ~clk_h_q[c]; pend[c] SHALL set on the clk_i edge ending the detect cycle.
REQ-020 An edge on c while pend[c]=1 or c is in service SHALL be dropped and SHALL set ovr_o[c].
REQ-021 With GET_EN=1, freeze_clk_o[c] SHALL rise together with pend[c] and fall on the cycle after the get payload for c is accepted.
REQ-022 FSM states: IDLE, GET, PUT, ERR.
REQ-023 IDLE: if any pend bit is set, select ch round-robin starting at rr_ptr+1 mod NCH, clear pend[ch], set rr_ptr=ch, go to GET if GET_EN else PUT; no pend -> stay.
REQ-024 GET: get_req_o=1, get_ch_o=ch held; on get_vld_i=1, write rx_data_o[ch]=get_data_i, pulse rx_upd_o[ch], clear freeze_clk_o[ch], go to PUT if PUT_EN else IDLE.
REQ-025 PUT: on entry, snapshot tx_data_i[ch]; put_vld_o=1, put_ch_o=ch, put_data_o=snapshot, all held stable until put_rdy_i=1; then go to IDLE.
REQ-026 get_vld_i outside GET and put_rdy_i outside PUT SHALL be ignored.
REQ-027 Watchdog: counter cleared on entry to GET and to PUT, incremented each cycle waiting; when it reaches WDOG_MAX without handshake, go to ERR.
REQ-028 ERR: wdog_err_o=1, all freeze_clk_o=1, get_req_o=put_vld_o=0, pend capture stops; exit only via rst_i.
REQ-029 Minimum service latency: edge-detect cycle +1 pend, +1 GET, response same cycle -> rx_upd_o at cycle 3 after detect.
REQ-030 An edge on a channel not in service is captured normally while another channel is served.

Reset
REQ-031 On rst_i assertion, mid-operation or not, all outputs, pend, clk_h_q, rr_ptr=NCH-1, the watchdog and the FSM (IDLE) SHALL clear immediately; any handshake in flight is abandoned.
REQ-032 First rising clk_i after deassertion: clk_h_q samples clk_h_i; a mission clock already high at reset release SHALL NOT produce an edge.

Verification
REQ-033 NCH=4: edge on ch2, get_vld_i same cycle as get_req_o, data 0x1A5 -> rx_data_o[2]=0x1A5, rx_upd_o[2] one pulse, freeze_clk_o[2] high exactly while pending and waiting.
REQ-034 Simultaneous edges on ch0 and ch3 after reset -> service order ch0 then ch3; get_ch_o/put_ch_o follow the same order.
REQ-035 put_rdy_i held low 5 cycles while tx_data_i changes -> put_data_o stays equal to the value at PUT entry; IDLE on the cycle after put_rdy_i=1.
REQ-036 WDOG_MAX=16, get_vld_i never asserted -> ERR after 16 GET cycles; wdog_err_o=1, freeze_clk_o=4'hF until rst_i.
REQ-037 Second edge on ch1 while ch1 is pending -> ovr_o[1]=1 sticky; exactly one service of ch1.
REQ-038 rst_i pulsed during PUT with put_rdy_i low -> put_vld_o=0 immediately; no later put for that channel.
